// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO drain adapter: read/empty pops into a 3-entry skid buffer, valid/ready out
// Optional accepted-transfer counter on word_count: define FIFO_STREAM_READER_STATS_EN.
module fifo_stream_reader #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic [width-1:0] fifo_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic [7:0]       word_count
);

  logic [1:0]       occ;
  logic [1:0]       head;
  logic [1:0]       tail;
  logic             inflight;
  logic [width-1:0] mem [0:2];
  logic             pop;
  logic [2:0]       committed;

  // Words already held plus the one still coming out of the RAM must fit in 3 slots.
  assign committed = {1'b0, occ} + {2'b00, inflight};
  // Gated by reset so the FIFO is never popped while both sides are being cleared.
  assign fifo_rd   = reset && !fifo_empty && (committed < 3'd3);
  assign out_valid = (occ != 2'd0);
  assign out_data  = mem[head];
  assign pop       = out_valid && out_ready;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head     <= 2'd0;
      tail     <= 2'd0;
      mem[0]   <= '0;
      mem[1]   <= '0;
      mem[2]   <= '0;
    end else begin
      inflight <= fifo_rd;
      if (inflight) begin
        mem[tail] <= fifo_data;
        tail      <= next_ptr(tail);
      end
      if (pop) begin
        head <= next_ptr(head);
      end
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [7:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= 8'd0;
    end else if (pop) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign word_count = count_q;
`else
  assign word_count = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - randomized self-checking bench for fifo_stream_reader against a queue model
module tb_fifo_stream_reader;
  localparam int W = 4;
`ifdef FIFO_STREAM_READER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         fifo_empty = 1'b1;
  logic         fifo_rd;
  logic [W-1:0] fifo_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [7:0]   word_count;

  fifo_stream_reader #(.width(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_data  (fifo_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [W-1:0] src[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] dut_out[$];
  bit           m_infl = 1'b0;
  int           m_count = 0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  bit           rst_edge = 1'b1;
  bit           rst_req = 1'b0;
  int           rdy_mode = 0;
  bit           tr_rd[$];
  bit           tr_v[$];
  logic [W-1:0] tr_d[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, req, $time);
    end
  endtask

  // exp_q holds every word popped from the FIFO and not yet accepted downstream,
  // including the one still in flight (its last entry when m_infl is set).
  task automatic step();
    bit           exp_rd;
    bit           exp_v;
    int           held;
    logic [W-1:0] nxt;
    @(negedge clk);
    held   = exp_q.size() - int'(m_infl);
    exp_rd = reset && !fifo_empty && (exp_q.size() < 3);
    exp_v  = held > 0;
    chk("fifo_rd", fifo_rd, exp_rd);
    chk("out_valid", out_valid, exp_v);
    if (exp_v) chk("out_data", out_data, exp_q[0]);
    if (rst_edge) chk("rst_out_data", out_data, 0);
    if (prev_stall) chk("stall_hold", out_data, prev_data);
    chk("word_count", word_count, STATS ? (m_count % 256) : 0);
    chk("occ_bound", ({1'b0, dut.occ} + {2'b00, dut.inflight}) <= 3'd3, 1);
    tr_rd.push_back(fifo_rd);
    tr_v.push_back(out_valid);
    tr_d.push_back(out_data);
    if (out_valid && out_ready) dut_out.push_back(out_data);
    if (exp_v && out_ready) begin
      void'(exp_q.pop_front());
      m_count++;
    end
    prev_stall = exp_v && !out_ready;
    prev_data  = out_data;
    nxt = W'($urandom);
    if (fifo_rd && src.size() > 0) nxt = src.pop_front();
    if (exp_rd) exp_q.push_back(nxt);
    m_infl = exp_rd;
    @(posedge clk);
    rst_edge = !reset;
    if (rst_edge) begin
      exp_q.delete();
      m_infl     = 1'b0;
      m_count    = 0;
      prev_stall = 1'b0;
    end
    #1;
    fifo_data  = nxt;
    fifo_empty = (src.size() == 0);
    reset      = rst_req;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_trace();
    tr_rd.delete();
    tr_v.delete();
    tr_d.delete();
  endtask

  function automatic int rd_pulses();
    int n = 0;
    foreach (tr_rd[i]) n += int'(tr_rd[i]);
    return n;
  endfunction

  initial begin
    // reset held with a non-empty FIFO
    src.push_back(4'h1);
    src.push_back(4'h2);
    src.push_back(4'h3);
    fifo_empty = 1'b0;
    rdy_mode = 1;
    clear_trace();
    run_n(2);
    chk("t_rst_rd0", tr_rd[0], 0);
    chk("t_rst_rd1", tr_rd[1], 0);
    chk("t_rst_v0", tr_v[0], 0);
    chk("t_rst_v1", tr_v[1], 0);
    chk("t_rst_cnt", word_count, 0);
    rst_req = 1'b1;
    clear_trace();
    run_n(2);
    chk("t_rel_rd_low", tr_rd[0], 0);
    chk("t_rel_rd_first", tr_rd[1], 1);
    run_n(8);

    // single word 0xA
    src.push_back(4'hA);
    fifo_empty = 1'b0;
    clear_trace();
    run_n(6);
    chk("t_single_rd0", tr_rd[0], 1);
    chk("t_single_rd1", tr_rd[1], 0);
    chk("t_single_v1", tr_v[1], 0);
    chk("t_single_v2", tr_v[2], 1);
    chk("t_single_d2", tr_d[2], 4'hA);
    chk("t_single_v3", tr_v[3], 0);
    chk("t_single_cnt", word_count, STATS ? 4 : 0);

    // streaming 0x0..0xF
    for (int k = 0; k < 16; k++) src.push_back(W'(k));
    fifo_empty = 1'b0;
    clear_trace();
    run_n(22);
    chk("t_stream_v1", tr_v[1], 0);
    for (int k = 0; k < 16; k++) begin
      chk("t_stream_v", tr_v[2 + k], 1);
      chk("t_stream_d", tr_d[2 + k], k);
    end
    chk("t_stream_end", tr_v[18], 0);

    // backpressure: 8 words, consumer stalled for 10 cycles
    rdy_mode = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) src.push_back(W'(8 + k));
    fifo_empty = 1'b0;
    dut_out.delete();
    clear_trace();
    run_n(10);
    chk("t_bp_pulses", rd_pulses(), 3);
    chk("t_bp_v9", tr_v[9], 1);
    for (int k = 2; k < 10; k++) chk("t_bp_hold", tr_d[k], 4'h8);
    rdy_mode = 1;
    out_ready = 1'b1;
    run_n(14);
    chk("t_bp_n", dut_out.size(), 8);
    for (int k = 0; k < 8 && k < dut_out.size(); k++) chk("t_bp_order", dut_out[k], 8 + k);

    // FIFO runs empty while a word is in flight
    src.push_back(4'h5);
    fifo_empty = 1'b0;
    dut_out.delete();
    clear_trace();
    run_n(6);
    chk("t_inflight_pulses", rd_pulses(), 1);
    chk("t_inflight_n", dut_out.size(), 1);
    if (dut_out.size() > 0) chk("t_inflight_d", dut_out[0], 4'h5);

    // random traffic, random backpressure, occasional mid-stream reset
    rdy_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) src.push_back(W'($urandom));
        fifo_empty = 1'b0;
      end
      if (i % 400 == 399) begin
        rst_req = 1'b0;
        src.delete();
        step();
        rst_req = 1'b1;
      end
      step();
    end

    // counter wrap: 257 accepted transfers after a fresh reset
    rdy_mode = 1;
    src.delete();
    rst_req = 1'b0;
    step();
    rst_req = 1'b1;
    step();
    dut_out.delete();
    for (int k = 0; k < 257; k++) src.push_back(W'($urandom));
    fifo_empty = 1'b0;
    run_n(265);
    chk("t_wrap_n", dut_out.size(), 257);
    chk("t_wrap_cnt", word_count, STATS ? 1 : 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
